// File: rtl/tf_rom_stream_if.sv
// Load/read handshake bundle for the twiddle-factor ROM streamer.
interface tf_rom_stream_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 112
);
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_done;
  logic              rd_start;
  logic [ADDR_W-1:0] rd_base;
  logic [ADDR_W-1:0] rd_stride;
  logic [ADDR_W-1:0] rd_len;
  logic              busy;
  logic              tf_valid;
  logic [DATA_W-1:0] tf_data;
  logic              tf_last;
  logic              err_oob;

  modport master (
    output load_start, load_valid, load_data, rd_start, rd_base, rd_stride, rd_len,
    input  load_ready, load_done, busy, tf_valid, tf_data, tf_last, err_oob
  );

  modport slave (
    input  load_start, load_valid, load_data, rd_start, rd_base, rd_stride, rd_len,
    output load_ready, load_done, busy, tf_valid, tf_data, tf_last, err_oob
  );
endinterface

// File: rtl/tf_rom_stream.sv
// Loadable twiddle table streamed out as strided, modulo-DEPTH read bursts.
module tf_rom_stream #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 112,
  parameter int DEPTH  = 319
) (
  input logic            clk,
  input logic            rst_n,
  tf_rom_stream_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W-1:0] stride;
  logic [ADDR_W-1:0] remain;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   sum;
  logic [ADDR_W:0]   nxt;
  logic              start_bad;
  logic              wr_en;

  // Operands are both < DEPTH, so one conditional subtract is a full modulo.
  always_comb begin
    sum       = {1'b0, raddr} + {1'b0, stride};
    nxt       = (sum >= DEPTH_X) ? (sum - DEPTH_X) : sum;
    start_bad = ({1'b0, bus.rd_base} >= DEPTH_X) || ({1'b0, bus.rd_stride} >= DEPTH_X);
    wr_en     = (state == LOAD) && bus.load_valid;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= bus.load_data;
  end

  assign bus.load_ready = (state == LOAD);
  assign bus.busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      waddr         <= '0;
      raddr         <= '0;
      stride        <= '0;
      remain        <= '0;
      bus.load_done <= 1'b0;
      bus.tf_valid  <= 1'b0;
      bus.tf_last   <= 1'b0;
      bus.tf_data   <= '0;
      bus.err_oob   <= 1'b0;
    end else begin
      bus.load_done <= 1'b0;
      if ((state != IDLE) && (bus.load_start || bus.rd_start)) bus.err_oob <= 1'b1;
      case (state)
        IDLE: begin
          bus.tf_valid <= 1'b0;
          bus.tf_last  <= 1'b0;
          if (bus.load_start) begin
            state <= LOAD;
            waddr <= '0;
          end else if (bus.rd_start) begin
            if (start_bad) begin
              bus.err_oob <= 1'b1;
            end else if (bus.rd_len != '0) begin
              state  <= READ;
              raddr  <= bus.rd_base;
              stride <= bus.rd_stride;
              remain <= bus.rd_len;
            end
          end
        end
        LOAD: begin
          if (bus.load_valid) begin
            if (waddr == LAST_A) begin
              state         <= IDLE;
              bus.load_done <= 1'b1;
            end else begin
              waddr <= waddr + ADDR_W'(1);
            end
          end
        end
        READ: begin
          bus.tf_data  <= mem[raddr];
          bus.tf_valid <= 1'b1;
          bus.tf_last  <= (remain == ADDR_W'(1));
          raddr        <= nxt[ADDR_W-1:0];
          remain       <= remain - ADDR_W'(1);
          if (remain == ADDR_W'(1)) state <= DRAIN;
        end
        default: begin
          bus.tf_valid <= 1'b0;
          bus.tf_last  <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/tf_rom_stream.md
TF_ROM_STREAM -- requirements
Module: tf_rom_stream

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, address width in bits.
REQ-002 SHALL have parameter DATA_W, default 112, twiddle word width in bits.
REQ-003 SHALL have parameter DEPTH, default 319, number of stored words; DEPTH <= 2^ADDR_W.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port load_start  input  1  one-cycle pulse, begins a full-table load.
REQ-007 SHALL have port load_valid  input  1  load_data qualifier.
REQ-008 SHALL have port load_data  input  DATA_W  word to store.
REQ-009 SHALL have port load_ready  output  1  high while in LOAD.
REQ-010 SHALL have port load_done  output  1  one-cycle pulse after the final word is written.
REQ-011 SHALL have port rd_start  input  1  one-cycle pulse, begins a strided read burst.
REQ-012 SHALL have port rd_base, rd_stride, rd_len  input  ADDR_W each  start address, address step, word count; sampled on accepted rd_start.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port tf_valid  output  1  tf_data qualifier.
REQ-015 SHALL have port tf_data  output  DATA_W  registered twiddle word.
REQ-016 SHALL have port tf_last  output  1  high with final tf_valid of a burst.
REQ-017 SHALL have port err_oob  output  1  sticky error flag.

Function
REQ-018 SHALL implement states IDLE, LOAD, READ, DRAIN; storage is a synchronous single-port array of DEPTH x DATA_W, block-RAM inferable, contents not reset.
REQ-019 IDLE: load_start -> LOAD with write address 0; else rd_start -> READ; simultaneous load_start and rd_start -> LOAD wins, rd_start dropped.
REQ-020 LOAD: each cycle with load_valid=1 writes load_data at write address, address increments by 1; load_valid=0 stalls without write.
REQ-021 LOAD: write to address DEPTH-1 -> load_done=1 next cycle, return to IDLE.
REQ-022 READ: one read address issued per cycle, first = rd_base; tf_data/tf_valid for an address appear exactly 1 cycle after issue.
REQ-023 Next address = addr + rd_stride; if result >= DEPTH, subtract DEPTH (modular wrap), computed at ADDR_W+1 bits.
REQ-024 After rd_len addresses issued -> DRAIN for 1 cycle (last word output) -> IDLE; tf_last=1 coincides with final tf_valid.
REQ-025 tf_valid SHALL be continuous for exactly rd_len cycles per burst; tf_data holds last value when tf_valid=0.
REQ-026 rd_len=0 on rd_start -> no burst, stay IDLE, no tf_valid.
REQ-027 rd_base >= DEPTH or rd_stride >= DEPTH on rd_start -> burst rejected, stay IDLE, err_oob set.
REQ-028 load_start or rd_start while busy=1 SHALL be ignored and SHALL set err_oob.
REQ-029 err_oob SHALL clear only on reset.
REQ-030 busy SHALL rise the cycle after an accepted start and fall the cycle state returns to IDLE.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, counters 0, load_ready=0, load_done=0, busy=0, tf_valid=0, tf_last=0, tf_data=0, err_oob=0.
REQ-032 Reset mid-LOAD or mid-READ SHALL abort the operation without further writes or outputs; stored words already written remain valid.
REQ-033 Operation resumes from first rising edge after rst_n deassertion.

Verification (DEPTH=8, DATA_W=16)
REQ-034 load_start, 8 words 0x100..0x107 with one load_valid gap -> 8 writes, load_done one cycle after word 0x107, busy low next cycle.
REQ-035 rd_base=0, rd_stride=1, rd_len=8 -> tf_data 0x100..0x107 on 8 consecutive cycles, first 1 cycle after first issue, tf_last with 0x107.
REQ-036 rd_base=6, rd_stride=3, rd_len=4 -> addresses 6,1,4,7 -> 0x106,0x101,0x104,0x107.
REQ-037 rd_start with rd_base=9 -> no tf_valid, err_oob=1; rd_start while busy -> err_oob=1, burst unaffected.
REQ-038 same-cycle load_start and rd_start -> LOAD only; rd_len=0 -> no activity.
REQ-039 rst_n low at 3rd output of a burst -> all outputs 0 asynchronously; re-read confirms table unchanged.
